maxcut_search: RTL and testbench
================================

Name: maxcut_search

Overview:
- Sequential solver for the hard-wired 5-vertex max-cut graph (vertices a..e; edges a-b, a-c, a-d, b-e, c-d, d-e).
- Performs the generation side of the max-cut decision problem: instead of checking a supplied partition against k, it enumerates partitions and reports the best cut, its partition, and whether it meets k.
- Sits beside the combinational max-cut checker as its reference/solution generator for benches and demos.

Parameters:
- BITS, 3, width of cut values (k, best_cut); must hold 6 (max edges).
- EXPLOIT_SYM, 1, 1: fix a=0 and search 16 candidates; 0: search all 32 candidates.

Ports:
- clk  input  1  sole clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a search; sampled only in IDLE.
- k  input  BITS  cut threshold; latched on accepted start.
- busy  output  1  high while in SEARCH.
- done  output  1  one-cycle pulse when results are final.
- best_part  output  5  partition {a,b,c,d,e}, MSB = a.
- best_cut  output  BITS  edge count cut by best_part.
- found  output  1  best_cut >= latched k; valid from the done cycle.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE. busy, done, found, best_part and best_cut are all 0. Candidate counter and latched k are 0. Reset mid-SEARCH aborts with no done pulse.
- FSM states and transitions:
  - IDLE: start=1 -> SEARCH. On that edge: latch k, clear counter, clear best_cut, best_part and found.
  - SEARCH: each cycle evaluates one candidate.
  - SEARCH -> DONE after the last candidate (15, or 31 when EXPLOIT_SYM=0) is evaluated.
  - DONE: done=1 and found is updated for exactly one cycle, then -> IDLE unconditionally.
- Candidate mapping:
  - EXPLOIT_SYM=1: partition = {1'b0, cnt[3:0]}.
  - EXPLOIT_SYM=0: partition = cnt[4:0].
  - Counter increments by 1 from 0; no wrap is needed.
- Cut evaluation: number of edges whose endpoints differ, zero-extended to BITS, summed; range 0..6.
- Update rule: the cut register updates when cand_cut > best_cut (strict), so the first-found maximum wins ties.
  - Because best_cut clears to 0, a candidate with cut 0 never replaces the initial value. best_part stays 0 in that case, which is correct: partition 0 has cut 0.
- Latency: start accepted at edge T; candidate i is evaluated in cycle T+1+i; done is high in cycle T+17 (EXPLOIT_SYM=1) or T+33 (EXPLOIT_SYM=0). Next start is accepted no earlier than the cycle after done.
- start while busy or in DONE is ignored; changes to k during SEARCH are ignored.
- Outputs hold after done until the next accepted start or rst.
- found is 0 during SEARCH and computed from the latched k in DONE.
- rst and start in the same cycle: rst wins.

Decomposition:
- Shared package holds:
  - state enum (IDLE, SEARCH, DONE);
  - NUM_VERTICES=5 and NUM_EDGES=6;
  - edge endpoint index constants.
- Natural sub-module: maxcut_eval. It is combinational: a 5-bit partition in, a BITS-wide cut count out, using the same edge list as the checker. It is instantiated once, on the candidate path.

Test Plan:
- Search with k=5 (EXPLOIT_SYM=1): start at T -> done pulse in cycle T+17, busy high T+1..T+16, best_cut=5, best_part=5'b01010, found=1.
- k=6: best_cut=5, best_part=5'b01010, found=0; k=0: found=1.
- Tie ordering: candidate 5'b01110 also cuts 5 but comes later -> best_part remains 5'b01010.
- start pulsed at T+5 during SEARCH, and k changed to 7 mid-search -> no restart, done still at T+17, found computed against the original k=5 (=1).
- rst asserted in cycle T+8 -> next cycle busy=0, done never pulses, all outputs 0. A fresh start then completes normally with best_cut=5.
- EXPLOIT_SYM=0, k=5 -> done at T+33, best_cut=5, best_part=5'b01010, found=1. Cross-check: feed best_part and best_cut to the checker, which returns valid=1; feeding best_cut+1 returns 0.

Source files
------------

// File: rtl/maxcut_search_pkg.sv
// +-----------------------------------------------------------------------+
// | maxcut_search_pkg                                                     |
// | Shared types and graph constants for the 5-vertex max-cut solver.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package maxcut_search_pkg;

  localparam int NUM_VERTICES = 5;
  localparam int NUM_EDGES    = 6;

  // Vertex bit positions inside a partition word {a,b,c,d,e}.
  localparam logic [2:0] V_A = 3'd4;
  localparam logic [2:0] V_B = 3'd3;
  localparam logic [2:0] V_C = 3'd2;
  localparam logic [2:0] V_D = 3'd1;
  localparam logic [2:0] V_E = 3'd0;

  // Edge list: a-b, a-c, a-d, b-e, c-d, d-e.
  localparam logic [2:0] EDGE_U [NUM_EDGES] = '{V_A, V_A, V_A, V_B, V_C, V_D};
  localparam logic [2:0] EDGE_V [NUM_EDGES] = '{V_B, V_C, V_D, V_E, V_D, V_E};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/maxcut_search_eval.sv
// +-----------------------------------------------------------------------+
// | maxcut_eval                                                           |
// | Combinational cut counter: edges whose endpoints lie on opposite      |
// | sides of the supplied partition.                                      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module maxcut_eval
  import maxcut_search_pkg::*;
#(
  parameter int BITS = 3
) (
  input  logic [NUM_VERTICES-1:0] part,
  output logic [BITS-1:0]         cut
);

  logic [NUM_EDGES-1:0] w_diff;

  for (genvar gi = 0; gi < NUM_EDGES; gi++) begin : g_edge
    assign w_diff[gi] = part[EDGE_U[gi]] ^ part[EDGE_V[gi]];
  end

  always_comb begin
    cut = '0;
    for (int i = 0; i < NUM_EDGES; i++) begin
      cut = cut + BITS'(w_diff[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/maxcut_search.sv
// +-----------------------------------------------------------------------+
// | maxcut_search                                                         |
// | Sequential enumerator reporting the best cut, its partition and       |
// | whether it meets the latched threshold k.                             |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module maxcut_search
  import maxcut_search_pkg::*;
#(
  parameter int BITS        = 3,
  parameter int EXPLOIT_SYM = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BITS-1:0]         k,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_VERTICES-1:0] best_part,
  output logic [BITS-1:0]         best_cut,
  output logic                    found
);

  localparam logic [4:0] C_LAST = (EXPLOIT_SYM != 0) ? 5'd15 : 5'd31;

  state_t                    r_state;
  state_t                    w_next;
  logic [4:0]                r_cnt;
  logic [BITS-1:0]           r_k;
  logic [NUM_VERTICES-1:0]   w_cand;
  logic [BITS-1:0]           w_cand_cut;
  logic                      w_better;
  logic                      w_last;
  logic [BITS-1:0]           w_final_cut;

  // With a fixed at 0 only half the space is searched; complements cut equally.
  if (EXPLOIT_SYM != 0) begin : g_sym
    assign w_cand = {1'b0, r_cnt[3:0]};
  end else begin : g_full
    assign w_cand = r_cnt;
  end

  maxcut_eval #(
    .BITS (BITS)
  ) u_eval (
    .part (w_cand),
    .cut  (w_cand_cut)
  );

  assign w_better    = (w_cand_cut > best_cut);
  assign w_last      = (r_cnt == C_LAST);
  assign w_final_cut = w_better ? w_cand_cut : best_cut;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SEARCH;
      SEARCH:  if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      SEARCH:  busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Strict compare keeps the first candidate reaching the maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_k       <= '0;
      best_cut  <= '0;
      best_part <= '0;
      found     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_k       <= k;
            r_cnt     <= '0;
            best_cut  <= '0;
            best_part <= '0;
            found     <= 1'b0;
          end
        end
        SEARCH: begin
          r_cnt <= r_cnt + 5'd1;
          if (w_better) begin
            best_cut  <= w_cand_cut;
            best_part <= w_cand;
          end
          if (w_last) begin
            found <= (w_final_cut >= r_k);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_maxcut_search.sv
// +-----------------------------------------------------------------------+
// | tb_maxcut_search                                                      |
// | Directed bench for maxcut_search, symmetric and full-search builds.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_maxcut_search;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_s = 1'b0;
  logic       start_f = 1'b0;
  logic [2:0] k = 3'd0;

  logic       busy_s, done_s, found_s;
  logic [4:0] part_s;
  logic [2:0] cut_s;
  logic       busy_f, done_f, found_f;
  logic [4:0] part_f;
  logic [2:0] cut_f;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  maxcut_search #(.BITS(3), .EXPLOIT_SYM(1)) dut_sym (
    .clk(clk), .rst(rst), .start(start_s), .k(k),
    .busy(busy_s), .done(done_s), .best_part(part_s),
    .best_cut(cut_s), .found(found_s)
  );

  maxcut_search #(.BITS(3), .EXPLOIT_SYM(0)) dut_full (
    .clk(clk), .rst(rst), .start(start_f), .k(k),
    .busy(busy_f), .done(done_f), .best_part(part_f),
    .best_cut(cut_f), .found(found_f)
  );

  // Independent cut model: edges a-b, a-c, a-d, b-e, c-d, d-e; p = {a,b,c,d,e}.
  function automatic int ref_cut(input logic [4:0] p);
    ref_cut = int'(p[4] ^ p[3]) + int'(p[4] ^ p[2]) + int'(p[4] ^ p[1])
            + int'(p[3] ^ p[0]) + int'(p[2] ^ p[1]) + int'(p[1] ^ p[0]);
  endfunction

  // Start a search and watch until done; cycle 1 is the one right after acceptance.
  task automatic run_search(input logic [2:0] kk, input bit full,
                            output int done_at, output int busy_n);
    done_at = 0;
    busy_n  = 0;
    @(negedge clk);
    k = kk;
    if (full) start_f = 1'b1; else start_s = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
    start_s = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      if (full ? busy_f : busy_s) busy_n++;
      if ((full ? done_f : done_s) && done_at == 0) done_at = n;
      if (done_at != 0) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if ({busy_s, done_s, found_s, part_s, cut_s} !== 11'd0) begin
      errs++;
      $display("FAIL reset_sym: got %b want 0", {busy_s, done_s, found_s, part_s, cut_s});
    end
    vec++;
    if ({busy_f, done_f, found_f, part_f, cut_f} !== 11'd0) begin
      errs++;
      $display("FAIL reset_full: got %b want 0", {busy_f, done_f, found_f, part_f, cut_f});
    end
    rst = 1'b0;
  endtask

  task automatic test_search_k5;
    int d, b;
    run_search(3'd5, 1'b0, d, b);
    vec++;
    if (d !== 17) begin errs++; $display("FAIL k5_done_cycle: got %0d want 17", d); end
    vec++;
    if (b !== 16) begin errs++; $display("FAIL k5_busy_cycles: got %0d want 16", b); end
    vec++;
    if (cut_s !== 3'd5) begin errs++; $display("FAIL k5_cut: got %0d want 5", cut_s); end
    vec++;
    if (part_s !== 5'b01010) begin errs++; $display("FAIL k5_part_tie: got %b want 01010", part_s); end
    vec++;
    if (found_s !== 1'b1) begin errs++; $display("FAIL k5_found: got %b want 1", found_s); end
    @(negedge clk);
    vec++;
    if ({done_s, busy_s} !== 2'b00) begin errs++; $display("FAIL k5_done_pulse: got %b want 00", {done_s, busy_s}); end
    repeat (3) @(negedge clk);
    vec++;
    if ({part_s, cut_s, found_s} !== {5'b01010, 3'd5, 1'b1}) begin
      errs++;
      $display("FAIL k5_hold: got %b want 01010_101_1", {part_s, cut_s, found_s});
    end
  endtask

  task automatic test_thresholds;
    int d, b;
    run_search(3'd6, 1'b0, d, b);
    vec++;
    if ({cut_s, part_s, found_s} !== {3'd5, 5'b01010, 1'b0}) begin
      errs++;
      $display("FAIL k6_result: got %b want 101_01010_0", {cut_s, part_s, found_s});
    end
    run_search(3'd0, 1'b0, d, b);
    vec++;
    if (found_s !== 1'b1 || d !== 17) begin
      errs++;
      $display("FAIL k0_found: got found=%b done=%0d want found=1 done=17", found_s, d);
    end
  endtask

  task automatic test_found_low_in_search;
    int seen_high;
    seen_high = 0;
    @(negedge clk);
    k = 3'd0;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      if (found_s) seen_high++;
      @(negedge clk);
    end
    vec++;
    if (seen_high !== 0 || done_s !== 1'b1 || found_s !== 1'b1) begin
      errs++;
      $display("FAIL found_during_search: got high_cycles=%0d done=%b found=%b want 0 1 1",
               seen_high, done_s, found_s);
    end
  endtask

  task automatic test_ignore_start_and_k;
    int done_at;
    done_at = 0;
    @(negedge clk);
    k = 3'd5;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      if (n == 5) begin start_s = 1'b1; k = 3'd7; end
      if (n == 6) start_s = 1'b0;
      if (done_s && done_at == 0) done_at = n;
      if (done_at != 0) break;
      @(negedge clk);
    end
    vec++;
    if (done_at !== 17) begin errs++; $display("FAIL ignore_done_cycle: got %0d want 17", done_at); end
    vec++;
    if (found_s !== 1'b1) begin errs++; $display("FAIL ignore_latched_k: got %b want 1", found_s); end
    k = 3'd5;
  endtask

  task automatic test_reset_mid;
    int pulses, d, b;
    pulses = 0;
    @(negedge clk);
    k = 3'd5;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int n = 1; n < 8; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vec++;
    if ({busy_s, done_s, found_s, part_s, cut_s} !== 11'd0) begin
      errs++;
      $display("FAIL mid_reset_outputs: got %b want 0", {busy_s, done_s, found_s, part_s, cut_s});
    end
    rst = 1'b0;
    for (int n = 0; n < 25; n++) begin
      if (done_s || busy_s) pulses++;
      @(negedge clk);
    end
    vec++;
    if (pulses !== 0) begin errs++; $display("FAIL mid_reset_abort: got %0d active cycles want 0", pulses); end
    run_search(3'd5, 1'b0, d, b);
    vec++;
    if (d !== 17 || cut_s !== 3'd5) begin
      errs++;
      $display("FAIL mid_reset_restart: got done=%0d cut=%0d want 17 5", d, cut_s);
    end
  endtask

  task automatic test_full_search;
    int d, b;
    run_search(3'd5, 1'b1, d, b);
    vec++;
    if (d !== 33 || b !== 32) begin
      errs++;
      $display("FAIL full_timing: got done=%0d busy=%0d want 33 32", d, b);
    end
    vec++;
    if ({cut_f, part_f, found_f} !== {3'd5, 5'b01010, 1'b1}) begin
      errs++;
      $display("FAIL full_result: got %b want 101_01010_1", {cut_f, part_f, found_f});
    end
    vec++;
    if (ref_cut(part_f) !== int'(cut_f)) begin
      errs++;
      $display("FAIL full_checker_match: model cut %0d dut cut %0d", ref_cut(part_f), cut_f);
    end
    vec++;
    if (ref_cut(part_f) >= int'(cut_f) + 1) begin
      errs++;
      $display("FAIL full_checker_plus1: model cut %0d meets %0d, want not", ref_cut(part_f), cut_f + 1);
    end
  endtask

  initial begin
    test_reset();
    test_search_k5();
    test_thresholds();
    test_found_low_in_search();
    test_ignore_start_and_k();
    test_reset_mid();
    test_full_search();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

`default_nettype wire
